// File: rtl/lc3b_muldiv_seq_if.sv
// Shared types and the request/result/ALU bundle for the LC-3b multiply/divide sequencer.
// The slave modport is the sequencer side; the master modport is the execute stage plus ALU.

package lc3b_muldiv_pkg;
    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_and  = 4'd1,
        alu_not  = 4'd2,
        alu_pass = 4'd3,
        alu_sll  = 4'd4,
        alu_srl  = 4'd5,
        alu_sra  = 4'd6,
        alu_sub  = 4'd7
    } lc3b_aluop;
endpackage

interface lc3b_muldiv_seq_if;
    import lc3b_muldiv_pkg::*;

    logic      start;
    logic      op_div;
    logic      op_signed;
    lc3b_word  opa;
    lc3b_word  opb;
    logic      busy;
    logic      done;
    lc3b_word  result;
    lc3b_word  remainder;
    logic      dbz;
    lc3b_aluop alu_op;
    lc3b_word  alu_a;
    lc3b_word  alu_b;
    lc3b_word  alu_f;

    modport master (
        output start, op_div, op_signed, opa, opb, alu_f,
        input  busy, done, result, remainder, dbz, alu_op, alu_a, alu_b
    );

    modport slave (
        input  start, op_div, op_signed, opa, opb, alu_f,
        output busy, done, result, remainder, dbz, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/lc3b_muldiv_seq.sv
// 16-iteration shift-add multiply / restoring divide sequencer driving the shared LC-3b ALU.
// Define MULDIV_SIGNED_EN to honour op_signed (two's-complement via magnitude + sign fix-up).

module lc3b_muldiv_seq
    import lc3b_muldiv_pkg::*;
(
    input logic              clk,
    input logic              reset,
    lc3b_muldiv_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e    state_q;
    logic [3:0] cnt_q;
    lc3b_word  acc_q;
    lc3b_word  mcand_q;
    lc3b_word  mplier_q;
    lc3b_word  rem_q;
    lc3b_word  dvd_q;
    lc3b_word  dvs_q;
    lc3b_word  result_q;
    lc3b_word  remainder_q;
    logic      busy_q;
    logic      done_q;
    logic      dbz_q;
    logic      qneg_q;
    logic      rneg_q;

    logic      sgn_a;
    logic      sgn_b;
    lc3b_word  mag_a;
    lc3b_word  mag_b;
    lc3b_word  rem_sh;
    logic      div_ge;
    lc3b_word  mul_acc_d;
    lc3b_word  div_rem_d;
    lc3b_word  div_quo_d;
    lc3b_word  fin_res;
    lc3b_word  result_fix_d;
    lc3b_word  rem_fix_d;
    logic      last_iter;

`ifdef MULDIV_SIGNED_EN
    assign sgn_a = bus.op_signed & bus.opa[15];
    assign sgn_b = bus.op_signed & bus.opb[15];
`else
    logic unused_op_signed;
    assign unused_op_signed = bus.op_signed;
    assign sgn_a = 1'b0;
    assign sgn_b = 1'b0;
`endif

    assign mag_a = sgn_a ? (~bus.opa + 16'd1) : bus.opa;
    assign mag_b = sgn_b ? (~bus.opb + 16'd1) : bus.opb;

    // The partial remainder can momentarily need 17 bits when the divisor exceeds
    // 0x8000; the bit shifted out of rem_q forces the subtract in that case.
    assign rem_sh    = {rem_q[14:0], dvd_q[15]};
    assign div_ge    = rem_q[15] | (rem_sh >= dvs_q);
    assign div_rem_d = div_ge ? bus.alu_f : rem_sh;
    assign div_quo_d = {dvd_q[14:0], div_ge};
    assign mul_acc_d = mplier_q[0] ? bus.alu_f : acc_q;
    assign last_iter = (cnt_q == 4'd15);

    assign fin_res      = (state_q == S_DIV) ? div_quo_d : mul_acc_d;
    assign result_fix_d = qneg_q ? (~fin_res + 16'd1) : fin_res;
    assign rem_fix_d    = rneg_q ? (~div_rem_d + 16'd1) : div_rem_d;

    always_comb begin
        bus.alu_op = alu_pass;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        case (state_q)
            S_MUL: begin
                bus.alu_op = alu_add;
                bus.alu_a  = acc_q;
                bus.alu_b  = mcand_q;
            end
            S_DIV: begin
                bus.alu_op = alu_sub;
                bus.alu_a  = rem_sh;
                bus.alu_b  = dvs_q;
            end
            default: ;
        endcase
    end

    // Result registers are loaded on the edge into DONE so they are valid with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        acc_q    <= '0;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        mcand_q  <= mag_a;
                        mplier_q <= mag_b;
                        dvd_q    <= mag_a;
                        dvs_q    <= mag_b;
                        qneg_q   <= sgn_a ^ sgn_b;
                        rneg_q   <= sgn_a & bus.op_div;
                        busy_q   <= 1'b1;
                        if (!bus.op_div) begin
                            state_q <= S_MUL;
                        end else if (bus.opb == '0) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            result_q    <= '1;
                            remainder_q <= bus.opa;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= mul_acc_d;
                    mcand_q  <= {mcand_q[14:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[15:1]};
                    cnt_q    <= cnt_q + 4'd1;
                    if (last_iter) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        result_q    <= result_fix_d;
                        remainder_q <= '0;
                        dbz_q       <= 1'b0;
                    end
                end
                S_DIV: begin
                    rem_q <= div_rem_d;
                    dvd_q <= div_quo_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (last_iter) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        result_q    <= result_fix_d;
                        remainder_q <= rem_fix_d;
                        dbz_q       <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.remainder = remainder_q;
    assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_lc3b_muldiv_seq.sv
// Scoreboard bench for lc3b_muldiv_seq: behavioural ALU, arithmetic reference model,
// latency/busy profile per operation, ignored-start and mid-operation reset cases.

module tb_lc3b_muldiv_seq;
    import lc3b_muldiv_pkg::*;

    typedef struct {
        lc3b_word result;
        lc3b_word remainder;
        logic     dbz;
        int       lat;
    } exp_t;

`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    exp_t scb[$];

    lc3b_muldiv_seq_if bus ();

    lc3b_muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_op)
            alu_add:  bus.alu_f = bus.alu_a + bus.alu_b;
            alu_sub:  bus.alu_f = bus.alu_a - bus.alu_b;
            alu_pass: bus.alu_f = bus.alu_a;
            default:  bus.alu_f = '0;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic div, input logic sgn, input lc3b_word a,
                                   input lc3b_word b);
        exp_t        e;
        logic [31:0] p;
        int          sa;
        int          sbv;
        logic        s;
        s = sgn & SIGNED_EN;
        e.dbz = 1'b0;
        e.lat = 17;
        if (div && b == 16'h0000) begin
            e.result    = 16'hFFFF;
            e.remainder = a;
            e.dbz       = 1'b1;
            e.lat       = 1;
        end else if (!div) begin
            p           = {16'h0000, a} * {16'h0000, b};
            e.result    = p[15:0];
            e.remainder = 16'h0000;
        end else if (s) begin
            sa          = $signed(a);
            sbv         = $signed(b);
            e.result    = 16'(sa / sbv);
            e.remainder = 16'(sa % sbv);
        end else begin
            e.result    = a / b;
            e.remainder = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (scb.size() == 0) begin
                check_eq("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = scb.pop_front();
                check_eq("result", 32'(bus.result), 32'(e.result));
                check_eq("remainder", 32'(bus.remainder), 32'(e.remainder));
                check_eq("dbz", 32'(bus.dbz), 32'(e.dbz));
            end
        end
    end

    // One operation: start in cycle 0, busy checked every cycle through done.
    // poke drives ignored starts in cycles 5 and 17; chain leaves cycle after done free
    // so the next call issues its start there.
    task automatic run_op(input logic div, input logic sgn, input lc3b_word a,
                          input lc3b_word b, input bit poke, input bit chain);
        exp_t e;
        int   c;
        bit   seen;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.op_div    = div;
        bus.op_signed = sgn;
        bus.opa       = a;
        bus.opb       = b;
        e = model(div, sgn, a, b);
        scb.push_back(e);
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            @(posedge clk); #1;
            c++;
            if (poke && (c == 5 || c == 17)) begin
                bus.start  = 1'b1;
                bus.op_div = 1'b1;
                bus.opa    = 16'hDEAD;
                bus.opb    = 16'h0000;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            check_eq("busy", 32'(bus.busy), 32'd1);
            if (c == 1) begin
                if (e.dbz)
                    check_eq("alu_op_c1", 32'(bus.alu_op), 32'(alu_pass));
                else if (div)
                    check_eq("alu_op_c1", 32'(bus.alu_op), 32'(alu_sub));
                else begin
                    check_eq("alu_op_c1", 32'(bus.alu_op), 32'(alu_add));
                    check_eq("alu_a_c1", 32'(bus.alu_a), 32'd0);
                    if (!(sgn & SIGNED_EN))
                        check_eq("alu_b_c1", 32'(bus.alu_b), 32'(a));
                end
            end
            if (bus.done) seen = 1'b1;
        end
        check_eq("latency", 32'(c), 32'(e.lat));
        if (!chain) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            check_eq("idle_busy", 32'(bus.busy), 32'd0);
            check_eq("idle_done", 32'(bus.done), 32'd0);
            check_eq("idle_alu_op", 32'(bus.alu_op), 32'(alu_pass));
            check_eq("hold_result", 32'(bus.result), 32'(e.result));
            check_eq("hold_remainder", 32'(bus.remainder), 32'(e.remainder));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op_div    = 1'b0;
        bus.op_signed = 1'b0;
        bus.opa       = '0;
        bus.opb       = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_result", 32'(bus.result), 32'd0);
        check_eq("rst_remainder", 32'(bus.remainder), 32'd0);
        check_eq("rst_dbz", 32'(bus.dbz), 32'd0);
        check_eq("rst_alu_op", 32'(bus.alu_op), 32'(alu_pass));
        check_eq("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check_eq("rst_alu_b", 32'(bus.alu_b), 32'd0);

        run_op(1'b0, 1'b0, 16'h0007, 16'h0006, 1'b0, 1'b0);
        run_op(1'b0, 1'b0, 16'h1234, 16'h0100, 1'b0, 1'b0);
        run_op(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 16'h0064, 16'h0007, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 16'hFFFF, 16'h8001, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b1);
        run_op(1'b0, 1'b0, 16'h0003, 16'h0005, 1'b1, 1'b0);

        // Reset in cycle 8 of a multiply: no done may follow and outputs return to 0.
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.op_div = 1'b0;
        bus.opa    = 16'h1234;
        bus.opb    = 16'h5678;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (c == 8) reset = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mrst_busy", 32'(bus.busy), 32'd0);
        check_eq("mrst_result", 32'(bus.result), 32'd0);
        check_eq("mrst_remainder", 32'(bus.remainder), 32'd0);
        check_eq("mrst_alu_op", 32'(bus.alu_op), 32'(alu_pass));
        check_eq("mrst_alu_b", 32'(bus.alu_b), 32'd0);
        repeat (25) @(posedge clk);

        run_op(1'b1, 1'b1, 16'hFFF9, 16'h0002, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 16'hFFFD, 16'h0004, 1'b0, 1'b0);
        run_op(1'b1, 1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0);
        run_op(1'b1, 1'b1, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom), 16'($urandom_range(0, 300)), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        check_eq("scb_empty", 32'(scb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
